rs_slot_scheduler: RTL

Sequencing controller for one reservation station (ALU or LS instance) in the out-of-order core. Tracks per-slot busy/ready state, hands the dispatcher the lowest-index free slot tag, and arbitrates ready slots to the execution unit round-robin. A slot is freed when its issue is accepted. Also supplies occupancy status to dispatch stall logic.

---
 rtl/rs_slot_scheduler_pkg.sv | 35 +++
 rtl/rs_slot_scheduler_picker.sv | 49 ++++
 rtl/rs_slot_scheduler.sv | 129 ++++++++++++
 3 files changed

// File: rtl/rs_slot_scheduler_pkg.sv
// Shared sizing, tag type and helpers for the reservation-station slot scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The NO_FREE_TAG value is also used by the existing free-tag table, so any
// change here has to stay in step with that table.
package rs_slot_scheduler_pkg;

    localparam int RS_SIZE = 6;
    localparam int TAG_W   = 3;

    typedef logic [TAG_W-1:0]   tag_t;
    typedef logic [RS_SIZE-1:0] slot_vec_t;
    typedef logic [2:0]         cnt_t;

    localparam tag_t NO_FREE_TAG = 3'b111;

    // Result of the round-robin pick: valid flag plus selected slot.
    typedef struct packed {
        logic vld;
        tag_t tag;
    } pick_t;

    // Advance a slot tag by one, wrapping at RS_SIZE (not at 2^TAG_W).
    function automatic tag_t tag_wrap_inc(input tag_t t);
        tag_t r;
        if (t == tag_t'(RS_SIZE - 1)) begin
            r = '0;
        end else begin
            r = t + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_slot_scheduler_picker.sv
// Round-robin picker: first set bit of req searching upward from rr_ptr, modulo RS_SIZE.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the pick is consumed.
//
// Ports:
//   req    - per-slot request vector (busy && ready)
//   rr_ptr - starting slot for the search, always 0..RS_SIZE-1
//   pick   - {vld, tag}; tag is NO_FREE_TAG when nothing is requested
module rs_rr_picker
    import rs_slot_scheduler_pkg::*;
(
    input  slot_vec_t req,
    input  tag_t      rr_ptr,
    output pick_t     pick
);

    logic [2*RS_SIZE-1:0] dbl;
    slot_vec_t            rot;
    tag_t                 off;
    logic                 found;
    logic [TAG_W:0]       sum;

    always_comb begin
        // Rotate so that slot rr_ptr lands at bit 0: duplicating the vector
        // lets a plain right shift do the modulo-RS_SIZE wrap.
        dbl   = {req, req} >> rr_ptr;
        rot   = dbl[RS_SIZE-1:0];
        found = |rot;

        // Lowest set bit of the rotated vector; descending loop so the
        // lowest index is the last write.
        off = '0;
        for (int j = RS_SIZE - 1; j >= 0; j--) begin
            if (rot[j]) begin
                off = tag_t'(j);
            end
        end

        // Undo the rotation, wrapping at RS_SIZE.
        sum = {1'b0, off} + {1'b0, rr_ptr};
        if (sum >= (TAG_W+1)'(RS_SIZE)) begin
            sum = sum - (TAG_W+1)'(RS_SIZE);
        end

        pick.vld = found;
        pick.tag = found ? sum[TAG_W-1:0] : NO_FREE_TAG;
    end

endmodule

// File: rtl/rs_slot_scheduler.sv
// Slot scheduler for one reservation station: free-slot allocation, wakeup tracking, round-robin issue.
// Latency: dispatch/wake/issue take effect at the next clk edge; disp_tag and issue_tag are combinational from state.
// Backpressure: disp_ready drops when all slots are busy; issue holds its pick until issue_ready.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   flush           - clears every slot at the next edge, overriding everything else
//   disp_valid/disp_ready/disp_tag/disp_src_ready - dispatch handshake and allocated slot
//   wake_mask       - per-slot operands-complete pulse from the RS data array
//   issue_valid/issue_ready/issue_tag - issue handshake toward the execution unit
//   free_count      - registered count of free slots; empty when all are free
module rs_slot_scheduler
    import rs_slot_scheduler_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               disp_valid,
    input  logic               disp_src_ready,
    output logic               disp_ready,
    output logic [TAG_W-1:0]   disp_tag,
    input  logic [RS_SIZE-1:0] wake_mask,
    output logic               issue_valid,
    output logic [TAG_W-1:0]   issue_tag,
    input  logic               issue_ready,
    output logic [2:0]         free_count,
    output logic               empty
);

    slot_vec_t busy;
    slot_vec_t rdy;
    tag_t      rr_ptr;
    cnt_t      free_cnt_q;

    slot_vec_t busy_d;
    slot_vec_t rdy_d;
    tag_t      rr_ptr_d;
    cnt_t      free_cnt_d;

    slot_vec_t disp_oh;
    slot_vec_t disp_set;
    slot_vec_t issue_clr;
    pick_t     issue_pick;
    logic      disp_fire;
    logic      issue_fire;

    // ------------------------------------------------------------------
    // Lowest-index free slot. Derived from busy only, so a slot freed by an
    // issue this cycle is not offered to dispatch until the next cycle and
    // dispatch and issue can never name the same slot.
    // ------------------------------------------------------------------
    always_comb begin
        disp_tag = NO_FREE_TAG;
        disp_oh  = '0;
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                disp_tag = tag_t'(i);
                disp_oh  = slot_vec_t'(1) << i;
            end
        end
    end

    assign disp_ready = ~&busy;
    assign disp_fire  = disp_valid && disp_ready;

    // ------------------------------------------------------------------
    // Issue selection: registered busy/rdy only, so nothing dispatched or
    // woken this cycle can issue before the next one.
    // ------------------------------------------------------------------
    rs_rr_picker u_picker (
        .req    (busy & rdy),
        .rr_ptr (rr_ptr),
        .pick   (issue_pick)
    );

    assign issue_valid = issue_pick.vld;
    assign issue_tag   = issue_pick.tag;
    assign issue_fire  = issue_valid && issue_ready;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        disp_set  = disp_fire ? disp_oh : '0;
        issue_clr = issue_fire ? (slot_vec_t'(1) << issue_tag) : '0;

        busy_d = (busy & ~issue_clr) | disp_set;

        // Wake only counts on busy slots. A slot being dispatched is not busy
        // yet, so its wake bit drops out here and its ready state comes from
        // disp_src_ready instead. A wake racing an issue of the same slot is
        // lost with the slot.
        rdy_d = ((rdy | (wake_mask & busy)) & ~issue_clr & ~disp_set)
              | (disp_src_ready ? disp_set : '0);

        rr_ptr_d = issue_fire ? tag_wrap_inc(issue_tag) : rr_ptr;

        case ({issue_fire, disp_fire})
            2'b10:   free_cnt_d = free_cnt_q + 3'd1;
            2'b01:   free_cnt_d = free_cnt_q - 3'd1;
            default: free_cnt_d = free_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            rdy        <= '0;
            rr_ptr     <= '0;
            free_cnt_q <= cnt_t'(RS_SIZE);
        end else if (flush) begin
            // The execution unit still sees any issue handshake this cycle
            // and drops it through its own flush.
            busy       <= '0;
            rdy        <= '0;
            rr_ptr     <= '0;
            free_cnt_q <= cnt_t'(RS_SIZE);
        end else begin
            busy       <= busy_d;
            rdy        <= rdy_d;
            rr_ptr     <= rr_ptr_d;
            free_cnt_q <= free_cnt_d;
        end
    end

    assign free_count = free_cnt_q;
    assign empty      = (free_cnt_q == cnt_t'(RS_SIZE));

endmodule
